// File: rtl/pt_tri_tx.sv
// rtl/pt_tri_tx.sv - trinary code serial transmitter with sync cell and frame repeats
module pt_tri_tx #(
    parameter int NBITS   = 12,
    parameter int ALPHA   = 4,
    parameter int REPEATS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*NBITS-1:0] ad,
    output logic               q,
    output logic               busy,
    output logic               done
);

    localparam int AW = (ALPHA   > 1) ? $clog2(ALPHA)   : 1;
    localparam int SW = (NBITS   > 1) ? $clog2(NBITS)   : 1;
    localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int DW = 2 * NBITS;

    localparam logic [AW-1:0] ALPHA_LAST = AW'(ALPHA - 1);
    localparam logic [SW-1:0] SYM_LAST   = SW'(NBITS - 1);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEATS - 1);

    typedef enum logic [1:0] {IDLE, BIT, SYNC} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] alpha_q, alpha_d;
    logic [4:0]    unit_q,  unit_d;
    logic [SW-1:0] sym_q,   sym_d;
    logic [RW-1:0] rep_q,   rep_d;
    logic [DW-1:0] sr_q,    sr_d;
    logic          q_q, q_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    function automatic logic cell_level(input logic [1:0] sym, input logic [2:0] u);
        case (sym)
            2'b00:   return (u == 3'd0) || (u == 3'd4);
            2'b01:   return (u != 3'd3) && (u != 3'd7);
            default: return (u == 3'd0) || ((u >= 3'd4) && (u <= 3'd6));
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alpha_q <= '0;
            unit_q  <= '0;
            sym_q   <= '0;
            rep_q   <= '0;
            sr_q    <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alpha_q <= alpha_d;
            unit_q  <= unit_d;
            sym_q   <= sym_d;
            rep_q   <= rep_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        unit_d  = unit_q;
        sym_d   = sym_q;
        rep_d   = rep_q;
        sr_d    = sr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BIT;
                    sr_d    = ad;
                    alpha_d = '0;
                    unit_d  = '0;
                    sym_d   = '0;
                    rep_d   = '0;
                end
            end
            BIT: begin
                if (alpha_q == ALPHA_LAST) begin
                    alpha_d = '0;
                    if (unit_q == 5'd7) begin
                        unit_d = '0;
                        // Rotate rather than shift so the word is intact again after NBITS cells
                        sr_d   = (sr_q << 2) | (sr_q >> (DW - 2));
                        if (sym_q == SYM_LAST) begin
                            sym_d   = '0;
                            state_d = SYNC;
                        end else begin
                            sym_d = sym_q + 1'b1;
                        end
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end else begin
                    alpha_d = alpha_q + 1'b1;
                end
            end
            SYNC: begin
                if (alpha_q == ALPHA_LAST) begin
                    alpha_d = '0;
                    if (unit_q == 5'd31) begin
                        unit_d = '0;
                        if (rep_q == REP_LAST) begin
                            rep_d   = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rep_d   = rep_q + 1'b1;
                            state_d = BIT;
                        end
                    end else begin
                        unit_d = unit_q + 1'b1;
                    end
                end else begin
                    alpha_d = alpha_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so q leads with latency 1
        busy_d = (state_d != IDLE);
        case (state_d)
            BIT:     q_d = cell_level(sr_d[DW-1 -: 2], unit_d[2:0]);
            SYNC:    q_d = (unit_d == 5'd0);
            default: q_d = 1'b0;
        endcase
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/pt_tri_tx.md
PT_TRI_TX -- requirements
Module: pt_tri_tx

Interface
REQ-001 SHALL have parameter NBITS, default 12, number of trinary code symbols per frame (range 1..32).
REQ-002 SHALL have parameter ALPHA, default 4, clk cycles per alpha unit (range 1..256).
REQ-003 SHALL have parameter REPEATS, default 4, frames sent per start (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  request to transmit, sampled on rising clk.
REQ-007 SHALL have port ad  input  2*NBITS  code word, 2 bits per symbol, MSB symbol first.
REQ-008 SHALL have port q  output  1  registered serial waveform.
REQ-009 SHALL have port busy  output  1  high while a transmission is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of the last frame.

Function
REQ-011 SHALL encode symbol 2'b00 as "zero", 2'b01 as "one", 2'b10 and 2'b11 as "float".
REQ-012 SHALL form each bit cell from 8 alpha units, numbered 0..7: zero = high on units 0 and 4; one = high on 0-2 and 4-6; float = high on 0 and 4-6; low otherwise.
REQ-013 SHALL form the sync cell from 32 alpha units: high on unit 0, low on units 1..31.
REQ-014 SHALL make each frame NBITS bit cells, MSB symbol first, followed by one sync cell, for a length of (8*NBITS+32)*ALPHA clocks.
REQ-015 SHALL use states IDLE, BIT, SYNC: IDLE->BIT on accepted start; BIT->BIT after each non-final cell; BIT->SYNC after cell NBITS-1; SYNC->BIT if frames sent < REPEATS; SYNC->IDLE after frame REPEATS.
REQ-016 SHALL accept start only when busy=0, capturing ad into an internal shift register on that edge.
REQ-017 SHALL ignore start and any change on ad while busy=1; the captured word is reused unchanged for every repeat.
REQ-018 SHALL drive q high and busy high on the clock after the accepting edge (latency 1).
REQ-019 SHALL keep q low and busy low in IDLE.
REQ-020 SHALL pulse done high for exactly one cycle, in the first IDLE cycle after the last sync cell, with busy low in that cycle.
REQ-021 SHALL accept a start that is high during the done cycle, so q rises on the next clock with no gap cycle.
REQ-022 SHALL transmit exactly REPEATS*(8*NBITS+32)*ALPHA consecutive busy cycles per start.
REQ-023 SHALL size the alpha prescaler, unit, symbol and repeat counters to their parameter ranges without wrap-around error at the maximum values.
REQ-024 SHALL contain no combinational path from start or ad to q, busy or done.

Reset
REQ-025 SHALL, on rst_n low, immediately force q=0, busy=0, done=0, state=IDLE, and clear all counters and the shift register.
REQ-026 SHALL abort any transmission in progress on reset, with no done pulse.
REQ-027 SHALL accept start on the first rising clk after rst_n is released.

Verification
REQ-028 Defaults, ad=24'h000000, start pulse: q is 1 for 4 clocks, 0 for 12, 1 for 4, 0 for 12 on each of 12 cells, then 1 for 4 and 0 for 124; busy=1 for 2048 clocks; one done pulse.
REQ-029 Defaults, ad=24'h555555, then ad=24'hAAAAAA and 24'hFFFFFF: cells match the REQ-012 patterns for one and float respectively; 11 produces the same waveform as 10.
REQ-030 NBITS=1, ALPHA=1, REPEATS=1, ad=2'b01: q = 1,1,1,0,1,1,1,0 then 1 followed by 31 zeros; done on clock 41 after the accepting edge.
REQ-031 Start repeated mid-transmission with a different ad: no change to waveform or length; second start held high on the done cycle starts the next transmission with q high on the following clock.
REQ-032 rst_n pulled low in frame 2, cell 5: q and busy go low asynchronously, no done; a start after release gives a complete, correct 2048-clock transmission.
